// File: rtl/data_memory_pipe.sv
// MEM-stage data memory: byte-enable writes, valid/ready request port and a
// fixed-latency response pipeline. The array is zero-filled by hardware after reset.

module data_memory_pipe_lane #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  // Storage is deliberately not reset; the INIT sweep clears it.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

module data_memory_pipe #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                init_done
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] sweep_q, sweep_d;

  logic                 accept, in_range;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr, mem_raddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [NB-1:0]        mem_be;
  logic [NB-1:0][7:0]   rd_lanes;
  logic [DATA_W-1:0]    rd_word;

  // Stage 0 captures the array at the accept edge; stage READ_LAT drives the port.
  logic [READ_LAT:0]             vld_pipe_q, vld_pipe_d;
  logic [READ_LAT:0]             err_pipe_q, err_pipe_d;
  logic [READ_LAT:0][DATA_W-1:0] data_pipe_q, data_pipe_d;

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  // Out-of-range reads are steered to word 0 so the array is never indexed past DEPTH.
  assign mem_raddr = in_range ? req_addr : '0;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = 1'b0;
    mem_waddr = sweep_q[ADDR_W-1:0];
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      ST_INIT: begin
        mem_we  = 1'b1;
        mem_be  = '1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_W) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && req_we && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = req_addr;
          mem_wdata = req_wdata;
          mem_be    = req_be;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane
    data_memory_pipe_lane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .we    (mem_we && mem_be[k]),
      .waddr (mem_waddr),
      .wdata (mem_wdata[8*k +: 8]),
      .raddr (mem_raddr),
      .rdata (rd_lanes[k])
    );
  end

  assign rd_word = rd_lanes;

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[READ_LAT-1:0], accept};
    err_pipe_d  = {err_pipe_q[READ_LAT-1:0], accept && !in_range};
    data_pipe_d = {data_pipe_q[READ_LAT-1:0],
                   (accept && !req_we && in_range) ? rd_word : {DATA_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      vld_pipe_q  <= '0;
      err_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      vld_pipe_q  <= vld_pipe_d;
      err_pipe_q  <= err_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign resp_valid = vld_pipe_q[READ_LAT];
  assign resp_err   = vld_pipe_q[READ_LAT] && err_pipe_q[READ_LAT];
  assign resp_rdata = vld_pipe_q[READ_LAT] ? data_pipe_q[READ_LAT] : '0;
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised successor to the single-cycle byte data memory. Word width, depth and read latency are configurable.
- Adds byte-enable writes, a valid/ready request port and a fixed-latency response pipeline.
- Flags out-of-range accesses.
- Runs a hardware zero-fill sweep after reset, so the program sees deterministic memory contents without simulation-only initialisation.
- Sits in the MEM stage of the pipelined processor, between the ALU/address path and the writeback mux.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- READ_LAT, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- resp_valid  output  1  one-cycle pulse per accepted request.
- resp_rdata  output  DATA_W  read data.
- resp_err  output  1  the request's address was >= DEPTH.
- init_done  output  1  zero-fill sweep is complete.

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
  - Every pipeline valid bit is cleared.
  - Sweep counter = 0, FSM = INIT.
  - The storage array itself is not reset.
- FSM states: INIT, RUN.
  - INIT: each cycle, write 0 to word[sweep counter], then increment the counter. After word DEPTH-1 is written, move to RUN on the next edge. INIT therefore lasts exactly DEPTH cycles after rst_n rises.
  - req_ready=0 throughout INIT; requests presented during INIT are ignored.
  - RUN: req_ready=1 and init_done=1, both held until the next reset. RUN has no exit other than reset.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. One request can be accepted per cycle, back-to-back, with no bubbles.
- Write, address in range:
  - Bytes with req_be[k]=1 are updated at the accept edge; other bytes keep their old value.
  - req_be=0 changes nothing but still produces a response.
- Read: data is sampled from the array at the accept edge.
  - Read-first ordering: a read accepted on the same edge as an earlier write returns the pre-write data.
  - Request ordering is strictly in order, one request per edge, so same-address hazards arise only across cycles. A read accepted on the edge after a write returns the new data.
- Response: exactly READ_LAT rising edges after the accept edge, resp_valid=1 for one cycle.
  - For an in-range read: resp_rdata = read data, resp_err = 0.
  - For a write: resp_rdata = 0, resp_err = 0.
- Out of range (addr >= DEPTH):
  - No array write.
  - Response has resp_rdata = 0 and resp_err = 1.
  - The FSM is unaffected.
- Output gating: when resp_valid=0, resp_rdata=0 and resp_err=0. Garbage is never driven.
- Pipeline: a READ_LAT-stage shift register of {valid, err, data}.
  - Throughput is one response per cycle.
  - There is no response back-pressure; the consumer must always accept.
- Reset mid-operation:
  - All in-flight responses are dropped; no resp_valid appears after rst_n falls.
  - The FSM restarts INIT and re-zeroes the whole array.
- Width rules:
  - The sweep counter is ADDR_W+1 bits, so DEPTH = 2**ADDR_W terminates without wrap.
  - Addresses are used unsigned and are never truncated modulo DEPTH.

Test Plan (DATA_W=16, ADDR_W=8, DEPTH=200, READ_LAT=2 unless stated):
- Reset, then rst_n high:
  - req_ready=0 for exactly 200 cycles, then init_done=req_ready=1.
  - Reads of addresses 0, 100 and 199 each return 0x0000 with resp_err=0.
- Write addr 100, data 0xABCD, be=2'b11; then write addr 100, data 0x1234, be=2'b01; then read 100:
  - Three resp_valid pulses.
  - The read response is 0xAB34, arriving 2 cycles after its accept edge.
- Back-to-back reads of addresses 1..8, after writing value = 0x0100+addr to each:
  - 8 consecutive resp_valid cycles.
  - Data is 0x0101..0x0108, in order.
- Write addr 5, data 0xFFFF, then read addr 5 on the next cycle:
  - The read returns 0xFFFF.
  - Repeating with READ_LAT=1 and READ_LAT=4 gives latency 1 and 4 respectively.
- Write addr 250, data 0x5555:
  - The response has resp_err=1 and resp_rdata=0.
  - A subsequent read of addr 250 also gives err=1 with data 0.
  - Words 0..199 are unchanged.
- Assert rst_n low while 2 reads are in flight:
  - resp_valid stays 0.
  - After release, INIT runs again and a previously written word reads 0x0000.
